// File: rtl/uv_ahb_to_bus.sv
// AHB-Lite slave to simple valid/ready request-response bus bridge.
// Single outstanding transaction; bursts are executed as singles.
module uv_ahb_to_bus #(
  parameter int unsigned ALEN = 12,
  parameter int unsigned DLEN = 32,
  parameter int unsigned MLEN = DLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ahb_hsel,
  input  logic [ALEN-1:0] ahb_haddr,
  input  logic [1:0]      ahb_htrans,
  input  logic [2:0]      ahb_hsize,
  input  logic [2:0]      ahb_hburst,
  input  logic [3:0]      ahb_hprot,
  input  logic            ahb_hmastlock,
  input  logic            ahb_hwrite,
  input  logic [DLEN-1:0] ahb_hwdata,
  input  logic            ahb_hready,
  output logic [DLEN-1:0] ahb_hrdata,
  output logic            ahb_hreadyout,
  output logic            ahb_hresp,
  output logic            bus_req_vld,
  input  logic            bus_req_rdy,
  output logic            bus_req_read,
  output logic [ALEN-1:0] bus_req_addr,
  output logic [MLEN-1:0] bus_req_mask,
  output logic [DLEN-1:0] bus_req_data,
  input  logic            bus_rsp_vld,
  output logic            bus_rsp_rdy,
  input  logic [1:0]      bus_rsp_excp,
  input  logic [DLEN-1:0] bus_rsp_data
);

  localparam int unsigned K = $clog2(MLEN);
  localparam logic [2:0] MaxSize = 3'(K);

  typedef enum logic [2:0] {StIdle, StReq, StRsp, StErr1, StErr2} state_e;

  state_e          state_q, state_d;
  logic [ALEN-1:0] addr_q;
  logic            write_q;
  logic [2:0]      size_q;
  logic [DLEN-1:0] wdata_q;
  logic            first_q;

  logic accept, rsp_ok, open, take, illegal;
  logic unused_ok;

  assign unused_ok = ^{ahb_hburst, ahb_hprot, ahb_hmastlock, ahb_htrans[0]};

  assign accept  = ahb_hsel & ahb_hready & ahb_htrans[1];
  assign rsp_ok  = bus_rsp_vld & (bus_rsp_excp == 2'b00);
  // A new address phase can only be taken while the data phase completes.
  assign open    = (state_q == StIdle) | (state_q == StErr2) | ((state_q == StRsp) & rsp_ok);
  assign take    = accept & open;
  assign illegal = ahb_hsize > MaxSize;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (take) state_d = illegal ? StErr1 : StReq;
      StReq:   if (bus_req_rdy) state_d = StRsp;
      StRsp: begin
        if (bus_rsp_vld) begin
          if (bus_rsp_excp != 2'b00) state_d = StErr1;
          else if (take)             state_d = illegal ? StErr1 : StReq;
          else                       state_d = StIdle;
        end
      end
      StErr1:  state_d = StErr2;
      StErr2:  state_d = take ? (illegal ? StErr1 : StReq) : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ahb_hreadyout = 1'b1;
    ahb_hresp     = 1'b0;
    ahb_hrdata    = '0;
    bus_req_vld   = 1'b0;
    bus_rsp_rdy   = 1'b0;
    unique case (state_q)
      StIdle: ;
      StReq: begin
        bus_req_vld   = 1'b1;
        ahb_hreadyout = 1'b0;
      end
      StRsp: begin
        bus_rsp_rdy   = 1'b1;
        ahb_hreadyout = rsp_ok;
        if (rsp_ok) ahb_hrdata = bus_rsp_data;
      end
      StErr1: begin
        ahb_hreadyout = 1'b0;
        ahb_hresp     = 1'b1;
      end
      StErr2:  ahb_hresp = 1'b1;
      default: ;
    endcase
  end

  // Write data arrives live in the first REQ cycle; hold a copy for stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      first_q <= 1'b0;
    end else if (take) begin
      addr_q  <= ahb_haddr;
      write_q <= ahb_hwrite;
      size_q  <= ahb_hsize;
      first_q <= 1'b1;
    end else if ((state_q == StReq) && first_q) begin
      wdata_q <= ahb_hwdata;
      first_q <= 1'b0;
    end
  end

  logic [K-1:0] lo;
  assign lo = addr_q[K-1:0];

  always_comb begin
    bus_req_mask = '1;
    unique case (size_q)
      3'd0:    bus_req_mask = MLEN'(1) << lo;
      3'd1:    bus_req_mask = MLEN'(3) << (lo & ~K'(1));
      3'd2:    bus_req_mask = MLEN'(15) << (lo & ~K'(3));
      default: bus_req_mask = '1;
    endcase
  end

  assign bus_req_read = ~write_q;
  assign bus_req_addr = addr_q;
  assign bus_req_data = first_q ? ahb_hwdata : wdata_q;

endmodule

// File: tb/tb_uv_ahb_to_bus.sv
// Directed bench for uv_ahb_to_bus; single slave so hready follows hreadyout.
module tb_uv_ahb_to_bus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ahb_hsel = 1'b0;
  logic [11:0] ahb_haddr = '0;
  logic [1:0]  ahb_htrans = '0;
  logic [2:0]  ahb_hsize = '0;
  logic [2:0]  ahb_hburst = '0;
  logic [3:0]  ahb_hprot = '0;
  logic        ahb_hmastlock = 1'b0;
  logic        ahb_hwrite = 1'b0;
  logic [31:0] ahb_hwdata = '0;
  logic        ahb_hready;
  logic [31:0] ahb_hrdata;
  logic        ahb_hreadyout;
  logic        ahb_hresp;
  logic        bus_req_vld;
  logic        bus_req_rdy = 1'b0;
  logic        bus_req_read;
  logic [11:0] bus_req_addr;
  logic [3:0]  bus_req_mask;
  logic [31:0] bus_req_data;
  logic        bus_rsp_vld = 1'b0;
  logic        bus_rsp_rdy;
  logic [1:0]  bus_rsp_excp = '0;
  logic [31:0] bus_rsp_data = '0;

  int vectors = 0;
  int miscompares = 0;
  int hs = 0;
  int hs_mark;

  assign ahb_hready = ahb_hreadyout;

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && bus_req_vld && bus_req_rdy) hs <= hs + 1;

  uv_ahb_to_bus dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ahb_hsel      (ahb_hsel),
    .ahb_haddr     (ahb_haddr),
    .ahb_htrans    (ahb_htrans),
    .ahb_hsize     (ahb_hsize),
    .ahb_hburst    (ahb_hburst),
    .ahb_hprot     (ahb_hprot),
    .ahb_hmastlock (ahb_hmastlock),
    .ahb_hwrite    (ahb_hwrite),
    .ahb_hwdata    (ahb_hwdata),
    .ahb_hready    (ahb_hready),
    .ahb_hrdata    (ahb_hrdata),
    .ahb_hreadyout (ahb_hreadyout),
    .ahb_hresp     (ahb_hresp),
    .bus_req_vld   (bus_req_vld),
    .bus_req_rdy   (bus_req_rdy),
    .bus_req_read  (bus_req_read),
    .bus_req_addr  (bus_req_addr),
    .bus_req_mask  (bus_req_mask),
    .bus_req_data  (bus_req_data),
    .bus_rsp_vld   (bus_rsp_vld),
    .bus_rsp_rdy   (bus_rsp_rdy),
    .bus_rsp_excp  (bus_rsp_excp),
    .bus_rsp_data  (bus_rsp_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic phase(input logic [11:0] a, input logic w, input logic [2:0] s);
    ahb_hsel = 1'b1; ahb_htrans = 2'b10; ahb_haddr = a; ahb_hwrite = w; ahb_hsize = s;
  endtask

  task automatic no_phase();
    ahb_hsel = 1'b0; ahb_htrans = 2'b00;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with an active address phase present
    phase(12'h010, 1'b1, 3'd2);
    @(posedge clk); @(negedge clk);
    chk("rst_hreadyout", 64'(ahb_hreadyout), 64'd1);
    chk("rst_hresp", 64'(ahb_hresp), 64'd0);
    chk("rst_hrdata", 64'(ahb_hrdata), 64'd0);
    chk("rst_req_vld", 64'(bus_req_vld), 64'd0);
    chk("rst_rsp_rdy", 64'(bus_rsp_rdy), 64'd0);
    next_cycle(); rst_n = 1'b1; no_phase();

    // Word write, response one cycle late
    next_cycle(); phase(12'h010, 1'b1, 3'd2);
    @(negedge clk); chk("wr_idle_hready", 64'(ahb_hreadyout), 64'd1);
    next_cycle(); no_phase(); ahb_hwdata = 32'hDEADBEEF; bus_req_rdy = 1'b1;
    @(negedge clk);
    chk("wr_vld", 64'(bus_req_vld), 64'd1);
    chk("wr_read", 64'(bus_req_read), 64'd0);
    chk("wr_addr", 64'(bus_req_addr), 64'h010);
    chk("wr_mask", 64'(bus_req_mask), 64'hF);
    chk("wr_data", 64'(bus_req_data), 64'hDEADBEEF);
    chk("wr_hready_req", 64'(ahb_hreadyout), 64'd0);
    next_cycle(); bus_req_rdy = 1'b0;
    @(negedge clk);
    chk("wr_hready_rsp", 64'(ahb_hreadyout), 64'd0);
    chk("wr_rsp_rdy", 64'(bus_rsp_rdy), 64'd1);
    chk("wr_vld_rsp", 64'(bus_req_vld), 64'd0);
    next_cycle(); bus_rsp_vld = 1'b1;
    @(negedge clk);
    chk("wr_hready_ok", 64'(ahb_hreadyout), 64'd1);
    chk("wr_hresp_ok", 64'(ahb_hresp), 64'd0);
    next_cycle(); bus_rsp_vld = 1'b0;
    @(negedge clk);
    chk("wr_rsp_rdy_idle", 64'(bus_rsp_rdy), 64'd0);
    chk("wr_hs", 64'(hs), 64'd1);

    // Byte read at offset 3
    next_cycle(); phase(12'h003, 1'b0, 3'd0);
    next_cycle(); no_phase(); bus_req_rdy = 1'b1;
    @(negedge clk);
    chk("rd_vld", 64'(bus_req_vld), 64'd1);
    chk("rd_read", 64'(bus_req_read), 64'd1);
    chk("rd_addr", 64'(bus_req_addr), 64'h003);
    chk("rd_mask", 64'(bus_req_mask), 64'h8);
    next_cycle(); bus_req_rdy = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_data = 32'h11223344;
    @(negedge clk);
    chk("rd_hready", 64'(ahb_hreadyout), 64'd1);
    chk("rd_hrdata", 64'(ahb_hrdata), 64'h11223344);
    // Stray response in IDLE: ignored
    next_cycle();
    @(negedge clk);
    chk("stray_rsp_rdy", 64'(bus_rsp_rdy), 64'd0);
    chk("stray_hrdata", 64'(ahb_hrdata), 64'd0);
    next_cycle(); bus_rsp_vld = 1'b0;

    // Halfword write with three stalled cycles
    hs_mark = hs;
    phase(12'h026, 1'b1, 3'd1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); no_phase();
      ahb_hwdata = (i == 0) ? 32'hCAFEF00D : 32'h0;
      @(negedge clk);
      chk("bp_vld", 64'(bus_req_vld), 64'd1);
      chk("bp_addr", 64'(bus_req_addr), 64'h026);
      chk("bp_mask", 64'(bus_req_mask), 64'hC);
      chk("bp_data", 64'(bus_req_data), 64'hCAFEF00D);
      chk("bp_hready", 64'(ahb_hreadyout), 64'd0);
    end
    next_cycle(); bus_req_rdy = 1'b1;
    @(negedge clk);
    chk("bp_data_hs", 64'(bus_req_data), 64'hCAFEF00D);
    next_cycle(); bus_req_rdy = 1'b0; bus_rsp_vld = 1'b1;
    @(negedge clk); chk("bp_hready_ok", 64'(ahb_hreadyout), 64'd1);
    next_cycle(); bus_rsp_vld = 1'b0;
    @(negedge clk); chk("bp_hs_once", 64'(hs - hs_mark), 64'd1);

    // Error response
    phase(12'h040, 1'b0, 3'd2);
    next_cycle(); no_phase(); bus_req_rdy = 1'b1;
    @(negedge clk); chk("err_vld", 64'(bus_req_vld), 64'd1);
    next_cycle(); bus_req_rdy = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_excp = 2'b01;
    bus_rsp_data = 32'hFFFFFFFF;
    @(negedge clk);
    chk("err_rsp_hready", 64'(ahb_hreadyout), 64'd0);
    chk("err_rsp_hrdata", 64'(ahb_hrdata), 64'd0);
    next_cycle(); bus_rsp_vld = 1'b0; bus_rsp_excp = 2'b00;
    @(negedge clk);
    chk("err1_hready", 64'(ahb_hreadyout), 64'd0);
    chk("err1_hresp", 64'(ahb_hresp), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("err2_hready", 64'(ahb_hreadyout), 64'd1);
    chk("err2_hresp", 64'(ahb_hresp), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("err_idle_hready", 64'(ahb_hreadyout), 64'd1);
    chk("err_idle_hresp", 64'(ahb_hresp), 64'd0);

    // Doubleword on a 32-bit bus is illegal
    hs_mark = hs;
    phase(12'h000, 1'b1, 3'd3);
    next_cycle(); no_phase();
    @(negedge clk);
    chk("ill_vld", 64'(bus_req_vld), 64'd0);
    chk("ill_e1_hready", 64'(ahb_hreadyout), 64'd0);
    chk("ill_e1_hresp", 64'(ahb_hresp), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("ill_e2_hready", 64'(ahb_hreadyout), 64'd1);
    chk("ill_e2_hresp", 64'(ahb_hresp), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("ill_idle_hresp", 64'(ahb_hresp), 64'd0);
    chk("ill_no_hs", 64'(hs - hs_mark), 64'd0);

    // Back-to-back: second NONSEQ accepted in the OKAY cycle
    hs_mark = hs;
    phase(12'h100, 1'b0, 3'd2);
    next_cycle(); no_phase(); bus_req_rdy = 1'b1;
    @(negedge clk); chk("b2b_addr1", 64'(bus_req_addr), 64'h100);
    next_cycle(); bus_req_rdy = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_data = 32'h0BADF00D;
    phase(12'h104, 1'b1, 3'd2);
    @(negedge clk);
    chk("b2b_hready1", 64'(ahb_hreadyout), 64'd1);
    chk("b2b_hrdata1", 64'(ahb_hrdata), 64'h0BADF00D);
    next_cycle(); bus_rsp_vld = 1'b0; ahb_htrans = 2'b00; ahb_hwdata = 32'hA5A5A5A5;
    bus_req_rdy = 1'b1;
    @(negedge clk);
    chk("b2b_vld2", 64'(bus_req_vld), 64'd1);
    chk("b2b_addr2", 64'(bus_req_addr), 64'h104);
    chk("b2b_read2", 64'(bus_req_read), 64'd0);
    chk("b2b_data2", 64'(bus_req_data), 64'hA5A5A5A5);
    next_cycle(); bus_req_rdy = 1'b0; bus_rsp_vld = 1'b1;
    @(negedge clk); chk("b2b_hready2", 64'(ahb_hreadyout), 64'd1);
    next_cycle(); bus_rsp_vld = 1'b0;
    @(negedge clk); chk("idle_trans_vld", 64'(bus_req_vld), 64'd0);
    next_cycle(); no_phase();
    @(negedge clk);
    chk("idle_trans_vld2", 64'(bus_req_vld), 64'd0);
    chk("b2b_hs", 64'(hs - hs_mark), 64'd2);

    // Reset in the middle of a stalled request
    next_cycle(); phase(12'h200, 1'b1, 3'd2);
    next_cycle(); no_phase(); ahb_hwdata = 32'h00001234;
    @(negedge clk); chk("mid_vld", 64'(bus_req_vld), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(bus_req_vld), 64'd0);
    chk("mid_rst_hready", 64'(ahb_hreadyout), 64'd1);
    next_cycle(); rst_n = 1'b1;
    @(negedge clk); chk("mid_rel_vld", 64'(bus_req_vld), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("mid_rel_vld2", 64'(bus_req_vld), 64'd0);
    chk("mid_rel_rsp_rdy", 64'(bus_rsp_rdy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uv_ahb_to_bus.md
UV_AHB_TO_BUS -- requirements
Module: uv_ahb_to_bus

Interface
REQ-001 The block SHALL have parameter ALEN, default 12, meaning address width on both sides.
REQ-002 The block SHALL have parameter DLEN, default 32, meaning data width; the only legal values are 32 and 64.
REQ-003 The block SHALL have parameter MLEN, default DLEN/8, meaning byte-mask width.
REQ-004 The block SHALL have ports clk (input, 1, clock) and rst_n (input, 1, reset): reset rst_n, asynchronous, active-low; clock clk.
REQ-005 The block SHALL have AHB-Lite slave inputs: ahb_hsel (1), ahb_haddr (ALEN), ahb_htrans (2), ahb_hsize (3), ahb_hburst (3), ahb_hprot (4), ahb_hmastlock (1), ahb_hwrite (1), ahb_hwdata (DLEN) and ahb_hready (1, bus-wide ready).
REQ-006 The block SHALL have AHB-Lite slave outputs: ahb_hrdata (DLEN), ahb_hreadyout (1) and ahb_hresp (1, 1 = ERROR).
REQ-007 The block SHALL have bus request outputs bus_req_vld (1), bus_req_read (1), bus_req_addr (ALEN), bus_req_mask (MLEN) and bus_req_data (DLEN), plus input bus_req_rdy (1).
REQ-008 The block SHALL have bus response inputs bus_rsp_vld (1), bus_rsp_excp (2) and bus_rsp_data (DLEN), plus output bus_rsp_rdy (1).

Function
REQ-009 An address phase SHALL be accepted when ahb_hsel & ahb_hready & ahb_htrans[1] are all 1 at a clk edge; it SHALL capture haddr, hwrite and hsize. NONSEQ and SEQ SHALL be handled identically, with bursts executed as singles. hburst, hprot and hmastlock SHALL be ignored.
REQ-010 An IDLE or BUSY htrans, or hsel=0, SHALL produce no bus request; the data phase SHALL be answered zero-wait OKAY.
REQ-011 The block SHALL implement the states IDLE, REQ, RSP, ERR1 and ERR2.
REQ-012 In IDLE, an accepted legal transfer SHALL move to REQ; an accepted transfer with hsize > log2(MLEN) SHALL move to ERR1 without issuing a bus request.
REQ-013 In REQ, the block SHALL set bus_req_vld=1, bus_req_read=~hwrite_captured, bus_req_addr=haddr_captured, bus_req_data=ahb_hwdata (live data phase) and ahb_hreadyout=0; on bus_req_rdy=1 it SHALL move to RSP.
REQ-014 The request fields SHALL remain stable while bus_req_vld=1 and bus_req_rdy=0; bus_req_data SHALL be registered on the REQ entry cycle edge where needed to hold it stable.
REQ-015 In RSP, the block SHALL set bus_rsp_rdy=1; until bus_rsp_vld arrives, ahb_hreadyout SHALL be 0.
REQ-016 On bus_rsp_vld=1 with bus_rsp_excp=2'b00, the block SHALL drive ahb_hreadyout=1, ahb_hresp=0 and ahb_hrdata=bus_rsp_data combinationally in that cycle. If a new address phase is accepted in the same cycle, the next state SHALL follow REQ-012; otherwise the next state SHALL be IDLE.
REQ-017 On bus_rsp_vld=1 with bus_rsp_excp≠0, the block SHALL move to ERR1.
REQ-018 ERR1 SHALL drive hreadyout=0 and hresp=1 for one cycle, then move to ERR2.
REQ-019 ERR2 SHALL drive hreadyout=1 and hresp=1 for one cycle. A transfer accepted in ERR2 SHALL be handled per REQ-012; otherwise the next state SHALL be IDLE.
REQ-020 The mask SHALL be derived from the captured hsize and low address bits: byte = 1 << addr[k-1:0]; half = 2'b11 << {addr[k-1:1],1'b0}; word = 4'hF << {addr[k-1:2],2'b00}; dword (DLEN=64 only) = all ones. k is log2(MLEN), and results are truncated to MLEN bits.
REQ-021 Outside the RSP-OKAY cycle, ahb_hrdata SHALL be 0. Outside RSP, bus_rsp_rdy SHALL be 0.
REQ-022 A bus_rsp_vld arriving outside RSP SHALL be ignored and not acknowledged.
REQ-023 At most one bus transaction SHALL be outstanding at any time.

Reset
REQ-024 While rst_n=0, the block SHALL hold state=IDLE, ahb_hreadyout=1, ahb_hresp=0, ahb_hrdata=0, bus_req_vld=0, bus_rsp_rdy=0 and all captured registers at 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no request re-issued after release.

Verification
REQ-026 A bench SHALL cover a word write: addr 0x010, hsize=2, hwdata 0xDEADBEEF, req_rdy=1, rsp OKAY next cycle -> one request with read=0, mask=4'hF and data 0xDEADBEEF; hreadyout low for 2 cycles, then 1 with hresp=0.
REQ-027 A bench SHALL cover a byte read: addr 0x003, hsize=0, rsp_data 0x11223344 -> req read=1, mask=4'b1000, hrdata=0x11223344 in the hreadyout=1 cycle.
REQ-028 A bench SHALL cover backpressure: bus_req_rdy=0 for 3 cycles -> req_vld held with addr, mask and data stable; hreadyout=0 throughout; exactly one handshake.
REQ-029 A bench SHALL cover an error: rsp_excp=2'b01 -> hreadyout=0/hresp=1 for one cycle, then hreadyout=1/hresp=1 for one cycle, then IDLE OKAY.
REQ-030 A bench SHALL cover an illegal size: DLEN=32 with hsize=3 -> no bus_req_vld, then the two-cycle ERROR response.
REQ-031 A bench SHALL cover back-to-back transfers: a second NONSEQ accepted in the OKAY cycle of the first -> a second request issued without passing through IDLE; an IDLE htrans produces no request.
